charge_node_sense: RTL

Read-side controller for a modelled dynamic charge-storage node. It is the reader/refresher for a switch-driven storage node: it mirrors writes from the node's driver, ages the stored charge, and answers read requests with the held value or "unknown". It issues refresh requests before the charge decays and declares the value lost when decay completes. It sits beside the storage-node writer in the capacitor/switch test designs, as the synthesizable sense side.

---
 rtl/charge_node_sense_if.sv | 42 ++++
 rtl/charge_node_sense.sv | 107 ++++++++++
 2 files changed

// File: rtl/charge_node_sense_if.sv
// Handshake bundle between a storage-node driver
// and the charge_node_sense reader/refresher.
interface charge_node_sense_if #(
  parameter int CNT_W = 8
);
  logic             wr_en;
  logic             wr_data;
  logic             rd_req;
  logic             rd_valid;
  logic             rd_data;
  logic             rd_unknown;
  logic             refresh_req;
  logic             refresh_data;
  logic             refresh_ack;
  logic [CNT_W-1:0] age;

  modport master (
    output wr_en,
    output wr_data,
    output rd_req,
    output refresh_ack,
    input  rd_valid,
    input  rd_data,
    input  rd_unknown,
    input  refresh_req,
    input  refresh_data,
    input  age
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  rd_req,
    input  refresh_ack,
    output rd_valid,
    output rd_data,
    output rd_unknown,
    output refresh_req,
    output refresh_data,
    output age
  );
endinterface

// File: rtl/charge_node_sense.sv
// Sense side of a modelled dynamic storage node:
// mirrors writes, ages charge, refreshes, answers reads.
module charge_node_sense #(
  parameter int DECAY_CYCLES   = 50,
  parameter int REFRESH_MARGIN = 10,
  parameter int CNT_W          = 8
) (
  input logic                clk,
  input logic                rst,
  charge_node_sense_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY,
    HELD,
    REFRESH,
    DECAYED
  } state_t;

  localparam logic [CNT_W-1:0] REF_AGE =
    CNT_W'(DECAY_CYCLES - REFRESH_MARGIN);
  localparam logic [CNT_W-1:0] DEC_AGE =
    CNT_W'(DECAY_CYCLES);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] age_q;
  logic [CNT_W-1:0] age_d;
  logic [CNT_W-1:0] age_inc;
  logic             val_q;
  logic             val_d;
  logic             known;

  logic             rd_valid_q;
  logic             rd_data_q;
  logic             rd_unknown_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      age_q   <= '0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      val_q   <= val_d;
    end
  end

  // Write beats ack; ack only counts while refreshing.
  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    val_d   = val_q;
    age_inc = age_q + CNT_W'(1);
    priority case (1'b1)
      bus.wr_en: begin
        state_d = HELD;
        age_d   = '0;
        val_d   = bus.wr_data;
      end
      (bus.refresh_ack && state_q == REFRESH): begin
        state_d = HELD;
        age_d   = '0;
      end
      (state_q == HELD): begin
        age_d = age_inc;
        if (age_inc == REF_AGE)
          state_d = REFRESH;
      end
      (state_q == REFRESH): begin
        age_d = age_inc;
        if (age_inc == DEC_AGE) begin
          state_d = DECAYED;
          val_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Reads see the pre-edge state, even if a write
  // or a decay lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q   <= 1'b0;
      rd_data_q    <= 1'b0;
      rd_unknown_q <= 1'b0;
    end else begin
      rd_valid_q   <= bus.rd_req;
      rd_data_q    <= bus.rd_req & known & val_q;
      rd_unknown_q <= bus.rd_req & ~known;
    end
  end

  always_comb begin
    known            = (state_q == HELD) ||
                       (state_q == REFRESH);
    bus.refresh_req  = (state_q == REFRESH);
    bus.refresh_data = (state_q == REFRESH) & val_q;
    bus.age          = age_q;
    bus.rd_valid     = rd_valid_q;
    bus.rd_data      = rd_data_q;
    bus.rd_unknown   = rd_unknown_q;
  end

endmodule
